// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared constants, types and helpers for the MEM stage
package mem_access_stage_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int OPCODE_BUS_W   = 7;

  typedef logic [REG_BUS_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
  typedef logic [OPCODE_BUS_W-1:0]   opcode_bus_t;

  localparam opcode_bus_t OPCODE_LOAD  = 7'b0000011;
  localparam opcode_bus_t OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores only accept the signed width codes; loads also allow BU/HU.
  function automatic logic access_legal(input logic is_load, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return ENABLE;
      F3_BU, F3_HU:     return is_load;
      default:          return DISABLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// rtl/mem_access_stage_load_extend.sv - sign/zero extension of an assembled load buffer
module load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [REG_BUS_W-1:0] buf_i,
  input  logic [2:0]           funct3_i,
  output logic [REG_BUS_W-1:0] data_o
);

  always_comb begin
    data_o = buf_i;
    case (funct3_i)
      F3_B:    data_o = {{24{buf_i[7]}}, buf_i[7:0]};
      F3_BU:   data_o = {24'd0, buf_i[7:0]};
      F3_H:    data_o = {{16{buf_i[15]}}, buf_i[15:0]};
      F3_HU:   data_o = {16'd0, buf_i[15:0]};
      default: data_o = buf_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: byte-serial loads/stores with stall request
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPCODE_BUS_W-1:0]   ex_opcode_i,
  input  logic [2:0]                ex_funct3_i,
  input  logic                      ex_we_i,
  input  logic [REG_ADDR_BUS_W-1:0] ex_waddr_i,
  input  logic [REG_BUS_W-1:0]      ex_alu_i,
  input  logic [REG_BUS_W-1:0]      ex_store_data_i,
  input  logic                      mem_hold_i,
  output logic [OPCODE_BUS_W-1:0]   mem_opcode_o,
  output logic                      mem_we_o,
  output logic [REG_ADDR_BUS_W-1:0] mem_waddr_o,
  output logic [REG_BUS_W-1:0]      mem_wdata_o,
  output logic                      bus_en_o,
  output logic                      bus_wr_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [7:0]                bus_dout_o,
  input  logic [7:0]                bus_din_i,
  input  logic                      bus_busy_i,
  output logic                      stallreq_from_mem_o
);

  mem_state_e     state_q, state_d;
  logic [2:0]     issue_cnt_q, issue_cnt_d;
  logic [2:0]     recv_cnt_q, recv_cnt_d;
  logic           pend_q, pend_d;
  reg_bus_t       buf_q, buf_merged, load_data;

  logic           is_load, is_store, is_mem, legal, active;
  logic           issue, capture, done_now;
  logic [2:0]     n_bytes, issue_idx, recv_idx;
  logic [31:0]    byte_addr;

  assign is_load  = (ex_opcode_i == OPCODE_LOAD);
  assign is_store = (ex_opcode_i == OPCODE_STORE);
  assign is_mem   = is_load | is_store;
  assign legal    = is_mem && access_legal(is_load, ex_funct3_i);
  assign n_bytes  = byte_count(ex_funct3_i);

  // IDLE behaves as ACCESS with both counters at zero, so byte 0 goes out on the first cycle.
  assign active    = rst && legal && (state_q != ST_DONE);
  assign issue_idx = (state_q == ST_ACCESS) ? issue_cnt_q : 3'd0;
  assign recv_idx  = (state_q == ST_ACCESS) ? recv_cnt_q : 3'd0;
  assign issue     = active && (issue_idx < n_bytes) && !bus_busy_i;
  assign capture   = rst && (state_q == ST_ACCESS) && pend_q;
  assign done_now  = active && (is_store ? (issue && (issue_idx == n_bytes - 3'd1))
                                         : (capture && (recv_idx == n_bytes - 3'd1)));
  assign byte_addr = ex_alu_i + {29'd0, issue_idx};

  always_comb begin
    buf_merged = buf_q;
    if (capture) buf_merged[{recv_idx[1:0], 3'b000} +: 8] = bus_din_i;
  end

  load_extend u_load_extend (
    .buf_i    (buf_merged),
    .funct3_i (ex_funct3_i),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 3'd0;
      recv_cnt_q  <= 3'd0;
      pend_q      <= DISABLE;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pend_q      <= pend_d;
      buf_q       <= buf_merged;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    pend_d      = DISABLE;
    unique case (state_q)
      ST_IDLE, ST_ACCESS: begin
        if (!active) begin
          state_d     = ST_IDLE;
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
        end else if (done_now) begin
          state_d     = mem_hold_i ? ST_DONE : ST_IDLE;
          issue_cnt_d = 3'd0;
          recv_cnt_d  = 3'd0;
        end else begin
          state_d     = ST_ACCESS;
          issue_cnt_d = issue_idx + {2'b00, issue};
          recv_cnt_d  = recv_idx + {2'b00, capture};
          pend_d      = issue && is_load;
        end
      end
      ST_DONE: begin
        if (!mem_hold_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_en_o            = issue;
    bus_wr_o            = issue && is_store;
    bus_addr_o          = '0;
    bus_dout_o          = 8'd0;
    if (issue) begin
      bus_addr_o = byte_addr[ADDR_W-1:0];
      bus_dout_o = ex_store_data_i[{issue_idx[1:0], 3'b000} +: 8];
    end
    stallreq_from_mem_o = active && !done_now;
    mem_opcode_o        = ex_opcode_i;
    mem_waddr_o         = ex_waddr_i;
    mem_we_o            = ex_we_i && !(is_mem && (!legal || is_store));
    mem_wdata_o         = (is_load && legal) ? load_data : ex_alu_i;
  end

endmodule
